// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR programmable-coefficient loader.
package fir_pkg;

  localparam int COEFF_WIDTH_DEF = 18;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } fir_loader_state_t;

  typedef logic signed [COEFF_WIDTH_DEF-1:0] coeff_t;

endpackage

// File: rtl/fir_coeff_shadow.sv
// Shadow coefficient bank: NTAPS words, one range-checked sync write port,
// one async read port, async clear to zero.
module fir_coeff_shadow #(
  parameter int NTAPS       = 8,
  parameter int COEFF_WIDTH = 18,
  parameter int ADDR_WIDTH  = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wr_en_i,
  input  logic [ADDR_WIDTH-1:0]  wr_addr_i,
  input  logic [COEFF_WIDTH-1:0] wr_data_i,
  output logic                   wr_oob_o,
  input  logic [ADDR_WIDTH-1:0]  rd_addr_i,
  output logic [COEFF_WIDTH-1:0] rd_data_o
);

  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(NTAPS);

  logic [COEFF_WIDTH-1:0] mem [NTAPS];

  // Extra MSB keeps the compare meaningful when NTAPS is a power of two.
  assign wr_oob_o = ({1'b0, wr_addr_i} >= DEPTH);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NTAPS; i++) mem[i] <= '0;
    end else if (wr_en_i && !wr_oob_o) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem[rd_addr_i];

endmodule

// File: rtl/fir_coeff_loader.sv
// Loads programmable FIR coefficients: buffers writes in a shadow bank and, on
// commit, shifts the bank into the taps' cascaded B registers (last tap first).
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int NTAPS       = 8,
  parameter int COEFF_WIDTH = COEFF_WIDTH_DEF,
  localparam int ADDR_WIDTH = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          wr_valid_i,
  output logic                          wr_ready_o,
  input  logic [ADDR_WIDTH-1:0]         wr_addr_i,
  input  logic signed [COEFF_WIDTH-1:0] wr_data_i,
  output logic                          wr_err_o,
  input  logic                          commit_i,
  output logic                          busy_o,
  output logic signed [COEFF_WIDTH-1:0] coeff_o,
  output logic                          coeff_ce_o,
  output logic                          coeff_done_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NTAPS - 1);

  fir_loader_state_t      state, state_d;
  logic [ADDR_WIDTH-1:0]  cnt, cnt_d, rd_addr;
  logic [COEFF_WIDTH-1:0] rd_data, coeff_d;
  logic                   wr_fire, wr_oob;
  logic                   ready_d, err_d, busy_d, ce_d, done_d;

  // Valid/ready: a write transfers on every clk_i edge where wr_valid_i && wr_ready_o
  // are both high; ready is only high in IDLE, so the bank is frozen while shifting.
  assign wr_fire = wr_valid_i && wr_ready_o;

  fir_coeff_shadow #(
    .NTAPS      (NTAPS),
    .COEFF_WIDTH(COEFF_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_shadow (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .wr_en_i  (wr_fire),
    .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i),
    .wr_oob_o (wr_oob),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      cnt          <= '0;
      wr_ready_o   <= 1'b0;
      wr_err_o     <= 1'b0;
      busy_o       <= 1'b0;
      coeff_o      <= '0;
      coeff_ce_o   <= 1'b0;
      coeff_done_o <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      wr_ready_o   <= ready_d;
      wr_err_o     <= err_d;
      busy_o       <= busy_d;
      coeff_o      <= coeff_d;
      coeff_ce_o   <= ce_d;
      coeff_done_o <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    rd_addr = LAST_IDX;
    coeff_d = '0;
    ce_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state)
      IDLE: begin
        err_d = wr_fire && wr_oob;
        if (commit_i) begin
          state_d = SHIFT;
          cnt_d   = LAST_IDX;
          ce_d    = 1'b1;
          // A write landing on the same edge must appear in the first word out.
          coeff_d = (wr_fire && !wr_oob && (wr_addr_i == LAST_IDX)) ? wr_data_i : rd_data;
        end
      end
      SHIFT: begin
        rd_addr = cnt - ADDR_WIDTH'(1);
        if (cnt == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt - ADDR_WIDTH'(1);
          ce_d    = 1'b1;
          coeff_d = rd_data;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader with a shadow-bank and tap-chain model.
module tb_fir_coeff_loader;

  localparam int NTAPS = 5;
  localparam int CW    = 18;
  localparam int AW    = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int WIN   = NTAPS + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [CW-1:0] wr_data = '0;
  logic          commit = 1'b0;
  logic          wr_ready, wr_err, busy, coeff_ce, coeff_done;
  logic [CW-1:0] coeff;

  always #5 clk = ~clk;

  fir_coeff_loader #(.NTAPS(NTAPS), .COEFF_WIDTH(CW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .wr_valid_i  (wr_valid),
    .wr_ready_o  (wr_ready),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .wr_err_o    (wr_err),
    .commit_i    (commit),
    .busy_o      (busy),
    .coeff_o     (coeff),
    .coeff_ce_o  (coeff_ce),
    .coeff_done_o(coeff_done)
  );

  int checks = 0;
  int errors = 0;

  // Reference: shadow bank contents and the taps' B cascade.
  logic [CW-1:0] sh_model [NTAPS];
  logic [CW-1:0] tap_model[NTAPS];
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] obs_q[$];
  int            obs_done_idx, obs_done_cnt, obs_leak, obs_busy_bad;
  logic          obs_ready_end, obs_busy_end;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [CW-1:0] d,
                       output logic acc, output logic err);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    acc      = wr_ready;
    step();
    err      = wr_err;
    wr_valid = 1'b0;
  endtask

  task automatic build_expected();
    exp_q.delete();
    for (int i = NTAPS - 1; i >= 0; i--) exp_q.push_back(sh_model[i]);
  endtask

  // Called right after the commit edge; records a fixed window of WIN cycles.
  task automatic collect_shift();
    obs_q.delete();
    obs_done_idx = -1;
    obs_done_cnt = 0;
    obs_leak     = 0;
    obs_busy_bad = 0;
    for (int i = 0; i < WIN; i++) begin
      if (i > 0) step();
      if (coeff_ce) begin
        obs_q.push_back(coeff);
        for (int k = NTAPS - 1; k > 0; k--) tap_model[k] = tap_model[k-1];
        tap_model[0] = coeff;
      end else if (coeff !== '0) begin
        obs_leak++;
      end
      if (coeff_done) begin
        obs_done_cnt++;
        if (obs_done_idx < 0) obs_done_idx = i;
      end
      if (i <= NTAPS && (busy !== 1'b1 || wr_ready !== 1'b0)) obs_busy_bad++;
      if (i == NTAPS) commit = 1'b0;
    end
    obs_ready_end = wr_ready;
    obs_busy_end  = busy;
  endtask

  task automatic test_reset();
    int ce_cnt = 0;
    #2 rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if ({wr_ready, wr_err, busy, coeff_ce, coeff_done} !== 5'b0 || coeff !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy/err/busy/ce/done=%b coeff=%h want 00000 coeff=0",
               {wr_ready, wr_err, busy, coeff_ce, coeff_done}, coeff);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_before_edge got %b want 0", wr_ready);
    end
    step();
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_after_edge got %b want 1", wr_ready);
    end
    repeat (4) begin
      step();
      if (coeff_ce || busy || coeff_done) ce_cnt++;
    end
    checks++;
    if (ce_cnt != 0) begin
      errors++; $display("FAIL idle_no_shift got %0d active cycles want 0", ce_cnt);
    end
  endtask

  task automatic test_pattern();
    logic acc, err;
    logic [CW-1:0] pat [NTAPS];
    pat = '{18'h00001, 18'h00002, 18'h3FFFF, 18'h1FFFF, 18'h20000};
    for (int i = 0; i < NTAPS; i++) begin
      write(AW'(i), pat[i], acc, err);
      checks++;
      if ({acc, err} !== 2'b10) begin
        errors++; $display("FAIL pattern_write[%0d] acc/err got %b%b want 10", i, acc, err);
      end
      sh_model[i] = pat[i];
    end
    build_expected();
    commit = 1'b1;
    step();
    collect_shift();
    checks++;
    if (obs_q.size() != NTAPS) begin
      errors++; $display("FAIL pattern_len got %0d want %0d", obs_q.size(), NTAPS);
    end
    for (int i = 0; i < NTAPS && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL pattern_coeff[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_done_idx != NTAPS || obs_done_cnt != 1) begin
      errors++; $display("FAIL pattern_done got idx=%0d cnt=%0d want idx=%0d cnt=1",
                         obs_done_idx, obs_done_cnt, NTAPS);
    end
    checks++;
    if (obs_leak != 0 || obs_busy_bad != 0) begin
      errors++; $display("FAIL pattern_flags got leak=%0d busy_bad=%0d want 0 0", obs_leak, obs_busy_bad);
    end
    checks++;
    if (obs_ready_end !== 1'b1 || obs_busy_end !== 1'b0) begin
      errors++; $display("FAIL pattern_end got ready=%b busy=%b want 1 0", obs_ready_end, obs_busy_end);
    end
    for (int k = 0; k < NTAPS; k++) begin
      checks++;
      if (tap_model[k] !== sh_model[k]) begin
        errors++; $display("FAIL pattern_tap[%0d] got %h want %h", k, tap_model[k], sh_model[k]);
      end
    end
  endtask

  task automatic test_write_with_commit();
    logic [CW-1:0] d;
    for (int pass = 0; pass < 2; pass++) begin
      d        = (pass == 0) ? 18'h00ABC : CW'($urandom);
      wr_valid = 1'b1;
      wr_addr  = (pass == 0) ? AW'(2) : AW'(NTAPS - 1);
      wr_data  = d;
      commit   = 1'b1;
      sh_model[wr_addr] = d;
      build_expected();
      step();
      wr_valid = 1'b0;
      collect_shift();
      checks++;
      if (obs_q.size() != NTAPS) begin
        errors++; $display("FAIL same_cycle_len[%0d] got %0d want %0d", pass, obs_q.size(), NTAPS);
      end
      for (int i = 0; i < NTAPS && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL same_cycle_coeff[%0d][%0d] got %h want %h", pass, i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (obs_done_idx != NTAPS || obs_done_cnt != 1) begin
        errors++; $display("FAIL same_cycle_done[%0d] got idx=%0d cnt=%0d want idx=%0d cnt=1",
                           pass, obs_done_idx, obs_done_cnt, NTAPS);
      end
    end
  endtask

  task automatic test_oob();
    logic acc, err;
    write(AW'(5), CW'($urandom), acc, err);
    checks++;
    if ({acc, err} !== 2'b11) begin
      errors++; $display("FAIL oob_err_pulse acc/err got %b%b want 11", acc, err);
    end
    step();
    checks++;
    if (wr_err !== 1'b0) begin
      errors++; $display("FAIL oob_err_width got %b want 0", wr_err);
    end
    write(AW'(7), CW'($urandom), acc, err);
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL oob_err_addr7 got %b want 1", err);
    end
    build_expected();
    commit = 1'b1;
    step();
    collect_shift();
    checks++;
    if (obs_q.size() != NTAPS) begin
      errors++; $display("FAIL oob_len got %0d want %0d", obs_q.size(), NTAPS);
    end
    for (int i = 0; i < NTAPS && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL oob_coeff[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_hold_and_stall();
    logic [CW-1:0] d;
    d = sh_model[0] ^ 18'h15A5A;
    build_expected();
    commit = 1'b1;
    step();
    wr_valid = 1'b1;
    wr_addr  = '0;
    wr_data  = d;
    collect_shift();
    checks++;
    if (obs_q.size() != NTAPS) begin
      errors++; $display("FAIL stall_len got %0d want %0d", obs_q.size(), NTAPS);
    end
    for (int i = 0; i < NTAPS && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL stall_coeff[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_done_cnt != 1 || obs_busy_bad != 0 || obs_ready_end !== 1'b1) begin
      errors++; $display("FAIL stall_handshake got done_cnt=%0d busy_bad=%0d ready=%b want 1 0 1",
                         obs_done_cnt, obs_busy_bad, obs_ready_end);
    end
    step();
    wr_valid = 1'b0;
    sh_model[0] = d;
    build_expected();
    commit = 1'b1;
    step();
    collect_shift();
    checks++;
    if (obs_q.size() != NTAPS || obs_q[NTAPS-1] !== exp_q[NTAPS-1]) begin
      errors++; $display("FAIL stall_accepted got len=%0d last=%h want len=%0d last=%h",
                         obs_q.size(), (obs_q.size() == NTAPS) ? obs_q[NTAPS-1] : '0,
                         NTAPS, exp_q[NTAPS-1]);
    end
  endtask

  task automatic test_random();
    logic acc, err;
    logic [AW-1:0] a;
    logic [CW-1:0] d;
    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < 8; w++) begin
        a = (w == 7) ? AW'(1) : AW'($urandom_range(0, (1 << AW) - 1));
        d = CW'($urandom);
        write(a, d, acc, err);
        checks++;
        if (acc !== 1'b1 || err !== (int'(a) >= NTAPS)) begin
          errors++; $display("FAIL rand_write[%0d][%0d] addr=%0d acc/err got %b%b want 1%b",
                             r, w, a, acc, err, int'(a) >= NTAPS);
        end
        if (int'(a) < NTAPS) sh_model[a] = d;
      end
      build_expected();
      commit = 1'b1;
      step();
      collect_shift();
      checks++;
      if (obs_q.size() != NTAPS || obs_done_idx != NTAPS) begin
        errors++; $display("FAIL rand_shape[%0d] got len=%0d done=%0d want %0d %0d",
                           r, obs_q.size(), obs_done_idx, NTAPS, NTAPS);
      end
      for (int k = 0; k < NTAPS; k++) begin
        checks++;
        if (tap_model[k] !== sh_model[k]) begin
          errors++; $display("FAIL rand_tap[%0d][%0d] got %h want %h", r, k, tap_model[k], sh_model[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    int ce_seen = 0;
    int late = 0;
    commit = 1'b1;
    step();
    commit = 1'b0;
    if (coeff_ce) ce_seen++;
    step();
    if (coeff_ce) ce_seen++;
    checks++;
    if (ce_seen != 2) begin
      errors++; $display("FAIL abort_pre got %0d enables want 2", ce_seen);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_ready, wr_err, busy, coeff_ce, coeff_done} !== 5'b0 || coeff !== '0) begin
      errors++; $display("FAIL abort_async got rdy/err/busy/ce/done=%b coeff=%h want 00000 coeff=0",
                         {wr_ready, wr_err, busy, coeff_ce, coeff_done}, coeff);
    end
    repeat (3) begin
      step();
      if (coeff_done || coeff_ce) late++;
    end
    checks++;
    if (late != 0) begin
      errors++; $display("FAIL abort_no_done got %0d active cycles want 0", late);
    end
    rst_n = 1'b1;
    for (int i = 0; i < NTAPS; i++) sh_model[i] = '0;
    step();
    build_expected();
    commit = 1'b1;
    step();
    collect_shift();
    checks++;
    if (obs_q.size() != NTAPS || obs_done_idx != NTAPS) begin
      errors++; $display("FAIL abort_reload_shape got len=%0d done=%0d want %0d %0d",
                         obs_q.size(), obs_done_idx, NTAPS, NTAPS);
    end
    for (int i = 0; i < NTAPS && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL abort_reload_coeff[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NTAPS; i++) begin
      sh_model[i]  = '0;
      tap_model[i] = '0;
    end
    test_reset();
    test_pattern();
    test_write_with_commit();
    test_oob();
    test_hold_and_stall();
    test_random();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
